// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the EXU M-extension issue port and an
// iterative radix-2 divider.
//
// Decodes DIV/DIVU/REM/REMU (and W forms), short-circuits divide-by-zero
// and signed overflow, reuses the last divider result through a one-entry
// cache (so DIV followed by REM on identical operands skips the divider),
// handles flush, and holds each result until writeback consumes it.
//
// Ports:
//   clk, rrst_n        clock, asynchronous active-low reset
//   req_*              op request from EXU (op: 00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   flush              kill the in-flight op (highest priority)
//   res_*              result towards writeback
//   dv_valid/dv_ready  start handshake to the divider, with its controls/operands
//   dv_flush           abort pulse to the divider
//   dv_out_valid, dv_quotient, dv_remainder   divider result
//   dbg_state          current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where valid and ready are both high; the sender keeps valid and its payload
// stable until that edge, and valid never depends combinationally on ready.
module div_ctrl #(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            dv_valid,
  input  logic            dv_ready,
  output logic            dv_signed,
  output logic            dv_w,
  output logic [XLEN-1:0] dv_dividend,
  output logic [XLEN-1:0] dv_divisor,
  output logic            dv_flush,
  input  logic            dv_out_valid,
  input  logic [XLEN-1:0] dv_quotient,
  input  logic [XLEN-1:0] dv_remainder,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic            sel_rem_q;   // op[1] of the accepted op: 1 selects remainder
  logic [XLEN-1:0] res_q, res_d;
  logic            dv_signed_q, dv_w_q;
  logic [XLEN-1:0] dv_a_q, dv_b_q;

  // One-entry result cache; the key is what the divider actually computed on.
  logic            c_valid;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;
  logic            c_signed, c_w;

  logic accept, issue_load, cache_wr, cache_inv;

  // W results are always rebuilt from bit 31, whatever the source put above it.
  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // Request classification (W ops are judged on the low 32 bits).
  logic            req_signed, b_zero, a_min, b_m1, special, hit;
  logic [XLEN-1:0] spec_res, hit_res, div_res;

  always_comb begin
    req_signed = ~req_op[0];
    b_zero     = req_w ? (req_b[31:0] == 32'h0) : (req_b == '0);
    a_min      = req_w ? (req_a[31:0] == 32'h8000_0000)
                       : (req_a == {1'b1, {(XLEN-1){1'b0}}});
    b_m1       = req_w ? (req_b[31:0] == 32'hFFFF_FFFF) : (req_b == '1);
    special    = b_zero | (req_signed & a_min & b_m1);

    // b==0: q=-1, r=a.  Overflow: q=a, r=0.
    if (b_zero) spec_res = req_op[1] ? req_a : '1;
    else        spec_res = req_op[1] ? '0 : req_a;
    if (req_w) spec_res = sext32(spec_res);

    hit = CACHE_EN && c_valid && (c_a == req_a) && (c_b == req_b) &&
          (c_signed == req_signed) && (c_w == req_w);
    hit_res = req_op[1] ? c_r : c_q;
    if (req_w) hit_res = sext32(hit_res);

    div_res = sel_rem_q ? dv_remainder : dv_quotient;
    if (dv_w_q) div_res = sext32(div_res);
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    accept     = 1'b0;
    issue_load = 1'b0;
    cache_wr   = 1'b0;
    cache_inv  = 1'b0;
    if (flush) begin
      // Flush wins everywhere; a divider run in progress is abandoned and
      // its operands can no longer be trusted as a cache key.
      state_d = S_IDLE;
      if (state_q == S_ISSUE || state_q == S_WAIT) cache_inv = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            accept = 1'b1;
            if (special) begin
              res_d   = spec_res;
              state_d = S_DONE;
            end else if (hit) begin
              res_d   = hit_res;
              state_d = S_DONE;
            end else begin
              issue_load = 1'b1;
              state_d    = S_ISSUE;
            end
          end
        end
        S_ISSUE: if (dv_ready) state_d = S_WAIT;
        S_WAIT: begin
          if (dv_out_valid) begin
            res_d    = div_res;
            cache_wr = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: if (res_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      sel_rem_q   <= 1'b0;
      res_q       <= '0;
      dv_signed_q <= 1'b0;
      dv_w_q      <= 1'b0;
      dv_a_q      <= '0;
      dv_b_q      <= '0;
      c_valid     <= 1'b0;
      c_a         <= '0;
      c_b         <= '0;
      c_q         <= '0;
      c_r         <= '0;
      c_signed    <= 1'b0;
      c_w         <= 1'b0;
    end else begin
      res_q <= res_d;
      if (accept) sel_rem_q <= req_op[1];
      if (issue_load) begin
        dv_signed_q <= ~req_op[0];
        dv_w_q      <= req_w;
        dv_a_q      <= req_a;
        dv_b_q      <= req_b;
      end
      if (cache_inv) begin
        c_valid <= 1'b0;
      end else if (cache_wr) begin
        c_valid  <= 1'b1;
        c_a      <= dv_a_q;
        c_b      <= dv_b_q;
        c_signed <= dv_signed_q;
        c_w      <= dv_w_q;
        c_q      <= dv_quotient;
        c_r      <= dv_remainder;
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign res_data    = res_q;
  assign dv_valid    = (state_q == S_ISSUE);
  assign dv_signed   = dv_signed_q;
  assign dv_w        = dv_w_q;
  assign dv_dividend = dv_a_q;
  assign dv_divisor  = dv_b_q;
  assign dv_flush    = flush && (state_q == S_ISSUE || state_q == S_WAIT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl.
// Expected results come from literal values (directed cases) or from a
// RISC-V division reference model (random cases); a monitor pops the
// expected queue on every result handshake.
module tb_div_ctrl;
  localparam int XLEN = 64;

  logic            clk, rrst_n;
  logic            req_valid, req_ready, req_w;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic            flush;
  logic            res_valid, res_ready;
  logic [XLEN-1:0] res_data;
  logic            dv_valid, dv_ready, dv_signed, dv_w, dv_flush, dv_out_valid;
  logic [XLEN-1:0] dv_dividend, dv_divisor, dv_quotient, dv_remainder;
  logic [1:0]      dbg_state;

  div_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rrst_n(rrst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dv_valid(dv_valid), .dv_ready(dv_ready), .dv_signed(dv_signed), .dv_w(dv_w),
    .dv_dividend(dv_dividend), .dv_divisor(dv_divisor), .dv_flush(dv_flush),
    .dv_out_valid(dv_out_valid), .dv_quotient(dv_quotient), .dv_remainder(dv_remainder),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [XLEN-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int dv_hs_cnt = 0;
  int fixed_lat = -1;
  bit rr_rand = 1'b1;
  logic cur_signed, cur_w;
  logic [XLEN-1:0] cur_a, cur_b;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V division semantics; W results sign-extended from bit 31.
  function automatic void arith(input logic s, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
    longint sa, sb;
    longint unsigned ua, ub;
    int sa32, sb32;
    int unsigned ua32, ub32;
    logic [31:0] q32, r32;
    q = '0; r = '0;
    if (w) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      if (ub32 == 0) begin q32 = '1; r32 = a[31:0]; end
      else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = '0;
      end else if (s) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else begin q32 = ua32 / ub32; r32 = ua32 % ub32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = a; sb = b; ua = a; ub = b;
      if (ub == 0) begin q = '1; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
      else if (s) begin q = sa / sb; r = sa % sb; end
      else begin q = ua / ub; r = ua % ub; end
    end
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    arith(~op[0], w, a, b, q, r);
    return op[1] ? r : q;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h0};
      4: return {$urandom, 32'hFFFF_FFFF};
      5: return {$urandom, 32'h8000_0000};
      6: return 64'($urandom_range(0, 40));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- divider model ----------------
  logic        pend, chk_drop;
  int          cnt;
  logic [63:0] pq, pr;
  initial begin
    pend = 1'b0; chk_drop = 1'b0; cnt = 0; pq = '0; pr = '0;
    dv_ready = 1'b0; dv_out_valid = 1'b0; dv_quotient = '0; dv_remainder = '0;
    forever begin
      @(negedge clk);
      if (chk_drop) begin
        chk("dv_valid_one_cycle", dv_valid, 1'b0);
        chk_drop = 1'b0;
      end
      if (!rrst_n || dv_flush) begin
        pend = 1'b0;
      end else if (dv_valid && dv_ready) begin
        dv_hs_cnt++;
        chk("dv_signed", dv_signed, cur_signed);
        chk("dv_w", dv_w, cur_w);
        chk("dv_dividend", dv_dividend, cur_a);
        chk("dv_divisor", dv_divisor, cur_b);
        arith(dv_signed, dv_w, dv_dividend, dv_divisor, pq, pr);
        if (dv_w) begin
          // Upper half deliberately junk: the controller must re-extend.
          pq[63:32] = $urandom;
          pr[63:32] = $urandom;
        end
        pend = 1'b1;
        cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 5);
        chk_drop = 1'b1;
      end
      @(posedge clk); #1;
      dv_out_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          dv_out_valid = 1'b1; dv_quotient = pq; dv_remainder = pr; pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      dv_ready = pend ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- writeback ready ----------------
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rrst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got %h expected none at %0t", res_data, $time);
      end else begin
        chk("res_data", res_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // mode 1: result must be ready one cycle after accept, divider untouched.
  // mode 2: op must go to the divider.
  task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input bit push, input int mode);
    int guard;
    guard = 0;
    while (!req_ready && guard < 500) begin @(posedge clk); #1; guard++; end
    if (!req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    cur_signed = ~op[0]; cur_w = w; cur_a = a; cur_b = b;
    if (push) exp_q.push_back(exp);
    req_valid = 1'b1; req_op = op; req_w = w; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (mode == 1) begin
      chk("fast_res_valid", res_valid, 1'b1);
      chk("fast_no_dv_valid", dv_valid, 1'b0);
    end else if (mode == 2) begin
      chk("issue_dv_valid", dv_valid, 1'b1);
      chk("issue_req_ready", req_ready, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int hs0);
    int guard;
    guard = 0;
    while (dv_hs_cnt == hs0 && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("dv_handshake_seen", 64'(dv_hs_cnt != hs0), 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin @(posedge clk); #1; guard++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  op, pop;
    logic        w, pw;
    logic [63:0] a, b, pa, pb;
    int hs0, guard;
    rrst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_w = 1'b0;
    req_a = '0; req_b = '0; flush = 1'b0;
    cur_signed = 1'b0; cur_w = 1'b0; cur_a = '0; cur_b = '0;

    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 64'h0);
    chk("rst_dv_valid", dv_valid, 1'b0);
    chk("rst_dv_flush", dv_flush, 1'b0);
    chk("rst_dv_dividend", dv_dividend, 64'h0);
    @(posedge clk); #1;
    rrst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Directed: normal, cache pairing, special cases, W re-extension.
    send(2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1, 2);
    send(2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 1'b1, 1);
    send(2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
    send(2'b10, 1'b1, 64'h1_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1);
    send(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1, 1);
    send(2'b00, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1);
    send(2'b10, 1'b1, 64'h8000_0000, '1, 64'h0, 1'b1, 1);
    send(2'b00, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 2);
    send(2'b10, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1);
    drain();

    // Result held while writeback stalls.
    rr_rand = 1'b0; res_ready = 1'b0;
    send(2'b00, 1'b0, 64'd1000, 64'd10, 64'd100, 1'b1, 2);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!res_valid && guard < 100);
    repeat (5) begin
      chk("hold_res_valid", res_valid, 1'b1);
      chk("hold_res_data", res_data, 64'd100);
      chk("hold_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
    rr_rand = 1'b1;

    // Flush in IDLE with a request pending: not accepted.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; req_w = 1'b0; req_a = 64'd9; req_b = 64'd2; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_req_ready", req_ready, 1'b1);
    chk("idle_flush_dv_valid", dv_valid, 1'b0);
    chk("idle_flush_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;

    // Flush 3 cycles into WAIT after caching DIV 300/7.
    send(2'b00, 1'b0, 64'd300, 64'd7, 64'd42, 1'b1, 2);
    drain();
    fixed_lat = 12;
    hs0 = dv_hs_cnt;
    send(2'b00, 1'b0, 64'd500, 64'd9, 64'd0, 1'b0, 2);
    wait_hs(hs0);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_dv_flush_pulse", dv_flush, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_dv_flush_drop", dv_flush, 1'b0);
    chk("flush_req_ready", req_ready, 1'b1);
    chk("flush_res_valid", res_valid, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    fixed_lat = -1;
    send(2'b10, 1'b0, 64'd300, 64'd7, 64'd6, 1'b1, 2);   // cache was invalidated
    send(2'b00, 1'b0, 64'd500, 64'd9, 64'd55, 1'b1, 2);
    drain();

    // Random ops against the reference model, with occasional operand reuse.
    pa = 64'd1; pb = 64'd1; pw = 1'b0; pop = 2'b00;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = pa; b = pb; w = pw; op = {~pop[1], pop[0]};
      end else begin
        a = pick_operand(); b = pick_operand(); w = 1'($urandom_range(0, 1));
        op = 2'($urandom_range(0, 3));
      end
      send(op, w, a, b, ref_result(op, w, a, b), 1'b1, 0);
      pa = a; pb = b; pw = w; pop = op;
    end
    drain();

    // Asynchronous reset in the middle of WAIT.
    fixed_lat = 12;
    hs0 = dv_hs_cnt;
    send(2'b00, 1'b1, 64'd77, 64'd5, 64'd0, 1'b0, 2);
    wait_hs(hs0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rrst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_res_valid", res_valid, 1'b0);
    chk("arst_res_data", res_data, 64'h0);
    chk("arst_dv_valid", dv_valid, 1'b0);
    chk("arst_dv_signed", dv_signed, 1'b0);
    chk("arst_dv_w", dv_w, 1'b0);
    chk("arst_dv_dividend", dv_dividend, 64'h0);
    chk("arst_dv_divisor", dv_divisor, 64'h0);
    chk("arst_dv_flush", dv_flush, 1'b0);
    @(posedge clk); #1;
    rrst_n = 1'b1;
    fixed_lat = -1;
    repeat (2) begin @(posedge clk); #1; end
    send(2'b10, 1'b1, 64'd77, 64'd5, 64'd2, 1'b1, 2);   // cache cleared by reset
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EXU M-extension issue port and the iterative radix-2 divider.
- Decodes DIV/DIVU/REM/REMU and their W forms into divider controls.
- Short-circuits RISC-V special cases (divide-by-zero, signed overflow) and pairs DIV/REM on identical operands via a one-entry result cache.
- Handles pipeline flush and holds each result until the writeback stage consumes it.

Parameters:
- XLEN, 64, operand/result width.
- CACHE_EN, 1, enables the one-entry quotient/remainder reuse cache (0 = every non-special op goes to the divider).

Ports:
- clk  in  1  clock
- rrst_n  in  1  reset
- req_valid  in  1  EXU presents a divide op
- req_ready  out  1  controller can accept an op
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_w  in  1  word (32-bit) variant
- req_a  in  XLEN  dividend (rs1)
- req_b  in  XLEN  divisor (rs2)
- flush  in  1  kill in-flight op
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- res_data  out  XLEN  final rd value, sign-extended from bit 31 for W ops
- dv_valid  out  1  start pulse to divider
- dv_ready  in  1  divider can accept
- dv_signed  out  1  signed divide
- dv_w  out  1  32-bit divide
- dv_dividend  out  XLEN  to divider
- dv_divisor  out  XLEN  to divider
- dv_flush  out  1  abort divider
- dv_out_valid  in  1  divider result valid
- dv_quotient  in  XLEN  divider quotient
- dv_remainder  in  XLEN  divider remainder

Behaviour:
- Reset: rrst_n, asynchronous, active-low; clock clk.
- Values under reset:
  - req_ready=1, res_valid=0, res_data=0, dv_valid=0, dv_flush=0, dv_* data=0.
  - FSM=IDLE, cache invalid.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. When req_valid is high, latch op/w/a/b and classify:
  - Special case: go to DONE with the result computed in the acceptance cycle.
  - Cache hit: go to DONE with the cached value.
  - Otherwise: go to ISSUE.
- Special cases (W ops judged on the low 32 bits):
  - b==0: quotient = all ones (-1), remainder = a.
  - Signed op with a == most-negative and b == -1: quotient = a, remainder = 0.
  - W results are sign-extended from bit 31.
- Cache:
  - Holds {a, b, signed, w, quotient, remainder}; written when dv_out_valid is high.
  - Hit = valid, and a, b, signed and w all match the new request (op type may differ).
  - Invalidated by a flush that aborts a divider run, and by reset.
- ISSUE:
  - Drive dv_valid=1 with dv_signed = ~op[0], dv_w = req_w, and operands.
  - Hold dv_valid until a cycle with dv_ready=1, then go to WAIT.
  - dv_valid is high for exactly that one handshake cycle.
- WAIT: on dv_out_valid, capture the result into res_data and the cache.
  - Quotient is selected when op[1]=0, remainder when op[1]=1.
  - Then go to DONE.
- DONE:
  - res_valid=1; res_data stable while res_ready is low.
  - When res_ready is high, go to IDLE. req_ready rises the next cycle; there is no back-to-back accept in the same cycle.
- Latency:
  - Special case or cache hit: res_valid is high 1 cycle after acceptance.
  - Normal op: 2 cycles plus divider iteration count.
- Flush (highest priority, any state):
  - Next state is IDLE; res_valid drops next cycle; the result is discarded.
  - In ISSUE or WAIT: dv_flush=1 for one cycle and the cache is invalidated.
  - A dv_out_valid arriving in the same cycle as flush is ignored.
  - A flush in IDLE with req_valid high: the request is not accepted.
- Divider result W sign-extension: res_data = {{32{r[31]}}, r[31:0]} regardless of the divider's own extension.
- dv_dividend and dv_divisor hold their values from ISSUE until the next accept.

Test Plan:
- DIV a=100, b=7 -> dv_valid pulse with dv_signed=1; after dv_out_valid, res_data=14.
- REM with the same operands next -> no dv_valid; res_valid 1 cycle after accept, res_data=2.
- DIVU a=5, b=0 -> no dv_valid, res_data=0xFFFF_FFFF_FFFF_FFFF. REMW a=0x1_8000_0001, b=0 -> res_data=0xFFFF_FFFF_8000_0001.
- DIV a=0x8000_0000_0000_0000, b=-1 -> quotient 0x8000_0000_0000_0000. DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000, REM of the same operands -> 0.
- Flush 3 cycles into WAIT -> dv_flush one-cycle pulse, FSM back to IDLE, no res_valid, next identical request misses the cache.
- res_ready held low 5 cycles in DONE -> res_data stable and req_ready=0 throughout. rrst_n asserted mid-WAIT -> all outputs return to reset values asynchronously.
